// File: rtl/sram_access_ctrl.sv
// Command sequencer for sram_top: serialises writes through the SIPO, strobes the
// array, and returns read words on a valid/ready response port.
module sram_access_ctrl #(
  parameter int ROWS      = 16,
  parameter int COLS      = 8,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2,
  localparam int AW       = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [COLS-1:0] cmd_wdata,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [COLS-1:0] rd_data,
  output logic            busy,
  output logic            sipo_arst_n,
  output logic            serial_in,
  output logic            shift,
  output logic            load,
  output logic            w_en,
  output logic            r_en,
  output logic [AW-1:0]   row_addr,
  input  logic [COLS-1:0] data_out
);

  // One shared down-counter, wide enough for the largest reload value.
  localparam int BW  = $clog2(COLS + 1);
  localparam int WW  = $clog2(WR_CYCLES + 1);
  localparam int RW  = $clog2(RD_CYCLES + 1);
  localparam int CW0 = (BW > WW) ? BW : WW;
  localparam int CW  = (CW0 > RW) ? CW0 : RW;

  typedef enum logic [2:0] {IDLE, SHIFT, LOAD, WRITE, READ, RESP} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [COLS-1:0] wdata_reg;
  logic [AW-1:0]   addr_reg;
  logic            shift_reg;
  logic            load_reg;
  logic            w_en_reg;
  logic            r_en_reg;
  logic            serial_reg;
  logic            rd_valid_reg;
  logic [AW-1:0]   row_addr_reg;
  logic [COLS-1:0] rd_data_reg;

  assign cmd_ready   = (state_reg == IDLE) && !rst;
  assign busy        = (state_reg != IDLE);
  assign sipo_arst_n = ~rst;
  assign serial_in   = serial_reg;
  assign shift       = shift_reg;
  assign load        = load_reg;
  assign w_en        = w_en_reg;
  assign r_en        = r_en_reg;
  assign row_addr    = row_addr_reg;
  assign rd_valid    = rd_valid_reg;
  assign rd_data     = rd_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      wdata_reg    <= '0;
      addr_reg     <= '0;
      shift_reg    <= 1'b0;
      load_reg     <= 1'b0;
      w_en_reg     <= 1'b0;
      r_en_reg     <= 1'b0;
      serial_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
      row_addr_reg <= '0;
      rd_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // cmd_ready is high here because rst is low and we are IDLE.
          if (cmd_valid) begin
            addr_reg <= cmd_addr;
            if (cmd_we) begin
              state_reg  <= SHIFT;
              cnt_reg    <= CW'(COLS);
              shift_reg  <= 1'b1;
              serial_reg <= cmd_wdata[COLS-1];
              wdata_reg  <= cmd_wdata << 1;
            end else begin
              state_reg    <= READ;
              cnt_reg      <= CW'(RD_CYCLES);
              r_en_reg     <= 1'b1;
              row_addr_reg <= cmd_addr;
            end
          end
        end
        SHIFT: begin
          if (cnt_reg == CW'(1)) begin
            state_reg  <= LOAD;
            shift_reg  <= 1'b0;
            serial_reg <= 1'b0;
            load_reg   <= 1'b1;
          end else begin
            cnt_reg    <= cnt_reg - CW'(1);
            serial_reg <= wdata_reg[COLS-1];
            wdata_reg  <= wdata_reg << 1;
          end
        end
        LOAD: begin
          state_reg    <= WRITE;
          load_reg     <= 1'b0;
          w_en_reg     <= 1'b1;
          row_addr_reg <= addr_reg;
          cnt_reg      <= CW'(WR_CYCLES);
        end
        WRITE: begin
          if (cnt_reg == CW'(1)) begin
            state_reg    <= IDLE;
            w_en_reg     <= 1'b0;
            row_addr_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        READ: begin
          // Sample the sense amps on the last edge r_en is still asserted.
          if (cnt_reg == CW'(1)) begin
            state_reg    <= RESP;
            r_en_reg     <= 1'b0;
            row_addr_reg <= '0;
            rd_data_reg  <= data_out;
            rd_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        RESP: begin
          if (rd_ready) begin
            state_reg    <= IDLE;
            rd_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: behavioural SRAM, cycle-schedule monitor and a
// read-data scoreboard fed from a reference memory.
module tb_sram_access_ctrl;

  localparam int C = 8;
  localparam int W = 2;
  localparam int R = 2;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       busy;
  logic       sipo_arst_n;
  logic       serial_in;
  logic       shift;
  logic       load;
  logic       w_en;
  logic       r_en;
  logic [3:0] row_addr;
  logic [7:0] data_out;

  sram_access_ctrl #(.ROWS(16), .COLS(C), .WR_CYCLES(W), .RD_CYCLES(R)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .sipo_arst_n(sipo_arst_n), .serial_in(serial_in),
    .shift(shift), .load(load), .w_en(w_en), .r_en(r_en),
    .row_addr(row_addr), .data_out(data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural sram_top: SIPO, parallel latch, word array, sense amps.
  logic [7:0] sipo_q;
  logic [7:0] latch_q;
  logic [7:0] mem [16];
  logic [7:0] init_val [16];
  logic       mem_init;

  always @(posedge clk or negedge sipo_arst_n) begin
    if (!sipo_arst_n) sipo_q <= '0;
    else if (shift)   sipo_q <= {sipo_q[6:0], serial_in};
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val[i];
    end else begin
      if (load) latch_q <= sipo_q;
      if (w_en) mem[row_addr] <= latch_q;
    end
  end

  assign data_out = r_en ? mem[row_addr] : 8'h00;

  // Reference model and scoreboard state.
  logic [7:0] ref_mem [16];
  logic [7:0] exp_q [$];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
  endtask

  task automatic bound_fail(input string what);
    total++;
    $display("FAIL timeout_%s: actual=no_event required=event_within_bound at t=%0t", what, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until it is accepted; update the reference on acceptance.
  task automatic issue(input logic we, input logic [3:0] a, input logic [7:0] d,
                       input bit commit, input bit keep);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      ok = cmd_ready;
      tick();
      if (ok) break;
    end
    if (!ok) bound_fail("accept");
    if (!keep) begin
      cmd_valid = 1'b0;
      cmd_addr  = 4'($urandom);
      cmd_wdata = 8'($urandom);
    end
    if (ok && commit) begin
      if (we) ref_mem[a] = d;
      else    exp_q.push_back(ref_mem[a]);
    end
  endtask

  task automatic wait_rd_valid();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rd_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("rd_valid");
  endtask

  task automatic complete_read(input int d);
    wait_rd_valid();
    repeat (d) tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  // Scoreboard: pop an expected word on every response handshake.
  initial forever begin
    @(negedge clk);
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL rd_unexpected: actual=0x%0h required=no_response at t=%0t", rd_data, $time);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Cycle-schedule monitor: expected strobes derived from the accepted command and cycle index.
  typedef enum int {M_IDLE, M_WR, M_RD, M_RESP} mode_t;
  initial begin
    mode_t      mode;
    int         cyc;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    logic [7:0] resp_data;
    bit         rst_prev;
    bit         first_resp;
    bit         was_idle;
    logic [11:0] act_v;
    logic [11:0] exp_v;
    mode = M_IDLE;
    cyc = 0;
    m_addr = '0;
    m_data = '0;
    resp_data = '0;
    rst_prev = 1'b0;
    first_resp = 1'b0;
    forever begin
      @(negedge clk);
      // {busy, cmd_ready, shift, load, w_en, r_en, serial_in, rd_valid, row_addr}
      act_v = {busy, cmd_ready, shift, load, w_en, r_en, serial_in, rd_valid, row_addr};
      exp_v = {1'b0, !rst, 10'b0};
      if (rst_prev) begin
        mode = M_IDLE;
        chk("reset_rd_data", 32'(rd_data), 32'h0);
      end else begin
        case (mode)
          M_WR: begin
            cyc++;
            if (cyc <= C)          exp_v = {4'b1010, 2'b00, m_data[C-cyc], 1'b0, 4'h0};
            else if (cyc == C + 1) exp_v = {4'b1001, 4'b0000, 4'h0};
            else                   exp_v = {4'b1000, 2'b10, 2'b00, m_addr};
          end
          M_RD: begin
            cyc++;
            exp_v = {4'b1000, 2'b01, 2'b00, m_addr};
          end
          M_RESP: exp_v = {4'b1000, 2'b00, 2'b01, 4'h0};
          default: ;
        endcase
      end
      chk("ctl", 32'(act_v), 32'(exp_v));
      chk("sipo_arst_n", 32'(sipo_arst_n), 32'(!rst));
      was_idle = (mode == M_IDLE);
      case (mode)
        M_WR: if (cyc == C + W + 1) mode = M_IDLE;
        M_RD: begin
          if (cyc == R) begin
            mode = M_RESP;
            first_resp = 1'b1;
          end
        end
        M_RESP: begin
          if (first_resp) resp_data = rd_data;
          else            chk("rd_data_stable", 32'(rd_data), 32'(resp_data));
          first_resp = 1'b0;
          if (rd_ready) mode = M_IDLE;
        end
        default: ;
      endcase
      if (rst) begin
        mode = M_IDLE;
      end else if (was_idle && cmd_valid && cmd_ready) begin
        m_addr = cmd_addr;
        m_data = cmd_wdata;
        cyc    = 0;
        mode   = cmd_we ? M_WR : M_RD;
      end
      rst_prev = rst;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=still_running required=finished at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       we_r;
    logic [3:0] a_r;
    logic [7:0] d_r;
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_we = 1'b1;
    cmd_addr = 4'd9;
    cmd_wdata = 8'h3C;
    rd_ready = 1'b0;
    mem_init = 1'b1;
    for (int i = 0; i < 16; i++) begin
      init_val[i] = 8'($urandom);
      ref_mem[i]  = init_val[i];
    end
    tick();
    mem_init = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    cmd_valid = 1'b0;
    tick();

    // Directed write then read-after-write with a 5-cycle stall.
    issue(1'b1, 4'd3, 8'hA5, 1'b1, 1'b0);
    issue(1'b0, 4'd3, 8'h00, 1'b1, 1'b0);
    complete_read(5);

    // Corner values at the extreme rows.
    issue(1'b1, 4'd0,  8'hFF, 1'b1, 1'b0);
    issue(1'b1, 4'd15, 8'h00, 1'b1, 1'b0);
    issue(1'b0, 4'd0,  8'h00, 1'b1, 1'b0);
    complete_read(1);
    issue(1'b0, 4'd15, 8'h00, 1'b1, 1'b0);
    complete_read(1);

    // Back-to-back writes with cmd_valid held high.
    issue(1'b1, 4'd7, 8'h5A, 1'b1, 1'b1);
    issue(1'b1, 4'd8, 8'hC3, 1'b1, 1'b0);
    issue(1'b0, 4'd7, 8'h00, 1'b1, 1'b0);
    complete_read(2);
    issue(1'b0, 4'd8, 8'h00, 1'b1, 1'b0);
    complete_read(2);

    // Reset in cycle 4 of a write, with a command presented during reset.
    issue(1'b1, 4'd5, 8'h96, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_we = 1'b1;
    cmd_addr = 4'd5;
    cmd_wdata = 8'h69;
    repeat (2) tick();
    rst = 1'b0;
    cmd_valid = 1'b0;
    tick();
    issue(1'b0, 4'd5, 8'h00, 1'b1, 1'b0);
    complete_read(1);

    // Reset while the response is pending.
    issue(1'b0, 4'd3, 8'h00, 1'b1, 1'b0);
    wait_rd_valid();
    tick();
    rst = 1'b1;
    exp_q.delete();
    cmd_valid = 1'b1;
    cmd_we = 1'b1;
    cmd_addr = 4'd3;
    cmd_wdata = 8'h00;
    tick();
    rst = 1'b0;
    cmd_valid = 1'b0;
    tick();
    issue(1'b0, 4'd3, 8'h00, 1'b1, 1'b0);
    complete_read(1);

    // Randomised traffic.
    for (int k = 0; k < 60; k++) begin
      we_r = 1'($urandom_range(0, 1));
      a_r  = 4'($urandom_range(0, 15));
      d_r  = 8'($urandom);
      issue(we_r, a_r, d_r, 1'b1, 1'b0);
      if (!we_r) complete_read(int'($urandom_range(1, 4)));
    end

    // Final sweep of every row.
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 4'(i), 8'h00, 1'b1, 1'b0);
      complete_read(1);
    end

    repeat (10) tick();
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL pending_responses: actual=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
